// File: rtl/fb_scanout_reader.sv
// Frame buffer scan-out reader: prefetches one row per video line into a
// ping-pong line buffer and streams palette indices in step with DrawX/DrawY.
module fb_scanout_reader #(
  parameter int unsigned FB_W       = 480,
  parameter int unsigned FB_H       = 360,
  parameter int unsigned X_OFF      = 80,
  parameter int unsigned Y_OFF      = 60,
  parameter logic [7:0]  BORDER_IDX = 8'h00,
  parameter int unsigned ADDR_W     = 18
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_en,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              frame_sel,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data_out,
  output logic              fb_frame,
  output logic              active,
  output logic [7:0]        pixel_idx,
  output logic              pixel_valid,
  output logic              underrun,
  input  logic              clr_underrun
);

  localparam int unsigned       COL_W    = $clog2(FB_W);
  localparam int unsigned       LB_D     = 2 * FB_W;
  localparam int unsigned       LB_AW    = $clog2(LB_D);
  localparam logic [9:0]        X_LO     = 10'(X_OFF);
  localparam logic [9:0]        X_HI     = 10'(X_OFF + FB_W);
  localparam logic [9:0]        Y_LO     = 10'(Y_OFF);
  localparam logic [9:0]        Y_HI     = 10'(Y_OFF + FB_H);
  localparam logic [9:0]        Y_TRIG   = 10'(Y_OFF - 1);
  localparam logic [9:0]        Y_LAST   = 10'(Y_OFF + FB_H - 2);
  localparam logic              Y_PAR    = 1'(Y_OFF % 2);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(FB_W - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] fetch_base;
  logic              half_q, half_d;
  logic [1:0]        line_ready_q, line_ready_d;
  logic              fb_frame_q, fb_frame_d;
  logic [7:0]        pixel_idx_q, pixel_idx_d;
  logic              pixel_valid_q;
  logic              underrun_q, underrun_d;

  logic              wr_en_q;
  logic              wr_half_q;
  logic [COL_W-1:0]  wr_col_q;

  logic [7:0]        linebuf [LB_D];

  logic              frame_trig, fetch_trig, in_win, ur_set;
  logic              disp_half, fetch_half;
  logic [COL_W-1:0]  disp_col;
  logic [LB_AW-1:0]  rd_idx, wr_idx;

  always_comb begin
    frame_trig = pix_en && (DrawX == '0) && (DrawY == Y_TRIG);
    fetch_trig = pix_en && (DrawX == '0) && (DrawY >= Y_TRIG) && (DrawY <= Y_LAST);
    in_win     = (DrawX >= X_LO) && (DrawX < X_HI) && (DrawY >= Y_LO) && (DrawY < Y_HI);
    // Only the parity of the row matters for choosing a half, so avoid the full subtract.
    disp_half  = DrawY[0] ^ Y_PAR;
    fetch_half = ~disp_half;
    disp_col   = COL_W'(DrawX - X_LO);
    rd_idx     = disp_half ? (LB_AW'(FB_W) + LB_AW'(disp_col)) : LB_AW'(disp_col);
    wr_idx     = wr_half_q ? (LB_AW'(FB_W) + LB_AW'(wr_col_q)) : LB_AW'(wr_col_q);
    ur_set     = (pix_en && in_win && !line_ready_q[disp_half]) ||
                 (fetch_trig && (state_q != IDLE));
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    fb_addr_d    = fb_addr_q;
    row_base_d   = row_base_q;
    half_d       = half_q;
    line_ready_d = line_ready_q;
    fb_frame_d   = fb_frame_q;
    pixel_idx_d  = pixel_idx_q;
    underrun_d   = underrun_q;
    fetch_base   = row_base_q;

    case (state_q)
      FETCH: begin
        if (col_q == COL_LAST) begin
          state_d = DRAIN;
        end else begin
          col_d     = col_q + COL_W'(1);
          fb_addr_d = fb_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        line_ready_d[half_q] = 1'b1;
        row_base_d           = row_base_q + ROW_STEP;
        state_d              = IDLE;
      end
      default: ;
    endcase

    if (frame_trig) begin
      fb_frame_d = frame_sel;
    end

    // A new trigger overrides whatever the FSM was doing; an aborted row still
    // consumes its slot so later rows stay row-aligned.
    if (fetch_trig) begin
      if (frame_trig) begin
        fetch_base = '0;
      end else if (state_q != IDLE) begin
        fetch_base = row_base_q + ROW_STEP;
      end
      state_d                  = FETCH;
      col_d                    = '0;
      fb_addr_d                = fetch_base;
      row_base_d               = fetch_base;
      half_d                   = fetch_half;
      line_ready_d[fetch_half] = 1'b0;
    end

    if (pix_en) begin
      pixel_idx_d = in_win ? linebuf[rd_idx] : BORDER_IDX;
    end

    if (clr_underrun) begin
      underrun_d = 1'b0;
    end
    if (ur_set) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      col_q         <= '0;
      fb_addr_q     <= '0;
      row_base_q    <= '0;
      half_q        <= 1'b0;
      line_ready_q  <= '0;
      fb_frame_q    <= 1'b0;
      pixel_idx_q   <= '0;
      pixel_valid_q <= 1'b0;
      underrun_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_half_q     <= 1'b0;
      wr_col_q      <= '0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      fb_addr_q     <= fb_addr_d;
      row_base_q    <= row_base_d;
      half_q        <= half_d;
      line_ready_q  <= line_ready_d;
      fb_frame_q    <= fb_frame_d;
      pixel_idx_q   <= pixel_idx_d;
      pixel_valid_q <= pix_en;
      underrun_q    <= underrun_d;
      // Read data arrives one cycle after its address, so the write side trails the fetch by one.
      wr_en_q       <= (state_q == FETCH);
      wr_half_q     <= half_q;
      wr_col_q      <= col_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en_q) begin
      linebuf[wr_idx] <= fb_data_out;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign fb_frame    = fb_frame_q;
  assign active      = (state_q != IDLE);
  assign pixel_idx   = pixel_idx_q;
  assign pixel_valid = pixel_valid_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Directed bench for fb_scanout_reader with a frame buffer model returning addr[7:0].
module tb_fb_scanout_reader;

  localparam int unsigned ADDR_W = 18;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pix_en;
  logic [9:0]        DrawX, DrawY;
  logic              frame_sel;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_data_out = 8'h00;
  logic              fb_frame, active, pixel_valid, underrun, clr_underrun;
  logic [7:0]        pixel_idx;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] exp_idx;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  fb_scanout_reader #(
    .BORDER_IDX(8'hA5)
  ) dut (
    .Clk          (clk),
    .Reset        (rst_n),
    .pix_en       (pix_en),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .frame_sel    (frame_sel),
    .fb_addr      (fb_addr),
    .fb_data_out  (fb_data_out),
    .fb_frame     (fb_frame),
    .active       (active),
    .pixel_idx    (pixel_idx),
    .pixel_valid  (pixel_valid),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
  );

  always @(posedge clk) fb_data_out <= fb_addr[7:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    pix_en = 1'b1;
    DrawX  = x;
    DrawY  = y;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (active && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(active), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    int addr_err;

    vecs[0]  = '{10'd80,  10'd60,  8'h00};
    vecs[1]  = '{10'd559, 10'd60,  8'hDF};
    vecs[2]  = '{10'd80,  10'd61,  8'hE0};
    vecs[3]  = '{10'd300, 10'd60,  8'hDC};
    vecs[4]  = '{10'd559, 10'd61,  8'hBF};
    vecs[5]  = '{10'd81,  10'd61,  8'hE1};
    vecs[6]  = '{10'd79,  10'd60,  8'hA5};
    vecs[7]  = '{10'd560, 10'd60,  8'hA5};
    vecs[8]  = '{10'd200, 10'd59,  8'hA5};
    vecs[9]  = '{10'd200, 10'd420, 8'hA5};
    vecs[10] = '{10'd79,  10'd61,  8'hA5};
    vecs[11] = '{10'd120, 10'd60,  8'h28};

    rst_n = 1'b0; pix_en = 1'b0; DrawX = '0; DrawY = '0;
    frame_sel = 1'b0; clr_underrun = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_fb_addr",     32'(fb_addr),     32'd0);
    chk("reset_fb_frame",    32'(fb_frame),    32'd0);
    chk("reset_active",      32'(active),      32'd0);
    chk("reset_pixel_idx",   32'(pixel_idx),   32'd0);
    chk("reset_pixel_valid", 32'(pixel_valid), 32'd0);
    chk("reset_underrun",    32'(underrun),    32'd0);
    rst_n = 1'b1;

    // Reset asserted mid-fetch, with an underrun and a valid pulse pending
    strobe(10'd0, 10'd59);
    strobe(10'd100, 10'd61);
    chk("pre_rst_active",   32'(active),      32'd1);
    chk("pre_rst_underrun", 32'(underrun),    32'd1);
    chk("pre_rst_valid",    32'(pixel_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_active",   32'(active),      32'd0);
    chk("async_rst_fb_addr",  32'(fb_addr),     32'd0);
    chk("async_rst_valid",    32'(pixel_valid), 32'd0);
    chk("async_rst_underrun", 32'(underrun),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", 32'(active), 32'd0);

    // Row 0 fetch with frame select latch
    frame_sel = 1'b1;
    strobe(10'd0, 10'd59);
    chk("frame_latch_1", 32'(fb_frame), 32'd1);
    cnt = 0;
    addr_err = 0;
    while (active && cnt < 1000) begin
      if (cnt < 480 && fb_addr != ADDR_W'(cnt)) addr_err++;
      cnt++;
      @(negedge clk);
    end
    chk("active_cycles", 32'(cnt), 32'd481);
    chk("fetch_addr_seq_errors", 32'(addr_err), 32'd0);

    // Row 1 fetch, then table of window and border pixels
    strobe(10'd0, 10'd60);
    wait_idle("row1_fetch_timeout");
    for (int i = 0; i < 12; i++) begin
      strobe(vecs[i].x, vecs[i].y);
      chk($sformatf("vec%0d_idx", i),   32'(pixel_idx),   32'(vecs[i].exp_idx));
      chk($sformatf("vec%0d_valid", i), 32'(pixel_valid), 32'd1);
      @(negedge clk);
      chk($sformatf("vec%0d_valid_drop", i), 32'(pixel_valid), 32'd0);
      chk($sformatf("vec%0d_idx_hold", i),   32'(pixel_idx),   32'(vecs[i].exp_idx));
    end
    chk("no_underrun_ready_lines", 32'(underrun), 32'd0);

    // frame_sel change mid-frame must not reach fb_frame
    frame_sel = 1'b0;
    strobe(10'd5, 10'd200);
    chk("frame_hold_midframe", 32'(fb_frame),  32'd1);
    chk("border_midframe",     32'(pixel_idx), 32'hA5);

    // Back-to-back triggers abort each fetch and step row_base to the last row
    for (int k = 0; k < 360; k++) begin
      @(negedge clk);
      pix_en = 1'b1;
      DrawX  = 10'd0;
      DrawY  = 10'(59 + k);
    end
    @(negedge clk);
    pix_en = 1'b0;
    chk("last_row_base",   32'(fb_addr),  32'd172320);
    chk("frame_latch_0",   32'(fb_frame), 32'd0);
    chk("abort_underrun",  32'(underrun), 32'd1);
    wait_idle("last_row_fetch_timeout");
    strobe(10'd559, 10'd419);
    chk("last_pixel_idx", 32'(pixel_idx), 32'hFF);
    strobe(10'd80, 10'd419);
    chk("last_row_col0_idx", 32'(pixel_idx), 32'h20);

    // Sticky underrun: set beats clear, then clear alone
    chk("underrun_sticky", 32'(underrun), 32'd1);
    @(negedge clk);
    pix_en = 1'b1; DrawX = 10'd100; DrawY = 10'd60; clr_underrun = 1'b1;
    @(negedge clk);
    pix_en = 1'b0; clr_underrun = 1'b0;
    chk("set_beats_clr", 32'(underrun), 32'd1);
    @(negedge clk);
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    chk("clr_underrun", 32'(underrun), 32'd0);
    @(negedge clk);
    chk("clr_underrun_stays", 32'(underrun), 32'd0);

    // Scan begins at row 60 without a row-0 fetch
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    strobe(10'd0, 10'd60);
    chk("late_start_no_underrun", 32'(underrun), 32'd0);
    chk("late_start_fb_frame",    32'(fb_frame), 32'd0);
    strobe(10'd80, 10'd60);
    chk("late_start_underrun", 32'(underrun), 32'd1);
    wait_idle("late_start_fetch_timeout");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
